decade_count_sequencer: RTL and testbench

//  Synchronous controller that sequences a chain of NDIG cascaded MOD-10 (BCD) digit stages.
//  It starts, pauses, clears and presets the chain, and advances the count once every

---
 rtl/decade_count_sequencer.sv | 137 +++++++++++++
 tb/tb_decade_count_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/decade_count_sequencer.sv
// Sequencer for a chain of cascaded BCD digit stages: start/stop/clear/preset control,
// prescaled count steps, terminal-count compare with halt or auto-reload.
module decade_count_sequencer #(
  parameter int unsigned NDIG     = 2,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              load,
  input  logic              auto_reload,
  input  logic [4*NDIG-1:0] preset,
  input  logic [4*NDIG-1:0] target,
  output logic [4*NDIG-1:0] Q,
  output logic              busy,
  output logic              tc_pulse,
  output logic [1:0]        state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [4*NDIG-1:0] q_q, q_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              busy_q, busy_d;
  logic              tc_q, tc_d;

  // Non-BCD digits in the preset load as zero.
  function automatic logic [4*NDIG-1:0] bcd_sanitize(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] r;
    r = v;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [4*NDIG-1:0] bcd_inc(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] r;
    logic              carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    presc_d = presc_q;
    tc_d    = 1'b0;

    if (clear) begin
      q_d     = '0;
      presc_d = '0;
      state_d = StIdle;
    end else if (load) begin
      q_d     = bcd_sanitize(preset);
      presc_d = '0;
      state_d = StIdle;
    end else if (stop) begin
      if (state_q == StRun) state_d = StPause;
    end else begin
      unique case (state_q)
        StRun: begin
          if (presc_q == PLast) begin
            presc_d = '0;
            // Q only ever holds valid BCD, so a target with a digit >9 never matches.
            if (q_q == target) begin
              tc_d = 1'b1;
              if (auto_reload) q_d = '0;
              else             state_d = StDone;
            end else begin
              q_d = bcd_inc(q_q);
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StIdle, StPause: begin
          if (start) state_d = StRun;
        end
        StDone: begin
          if (start) begin
            q_d     = '0;
            presc_d = '0;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= StIdle;
      q_q     <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
    end
  end

  assign Q        = q_q;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign state    = state_q;

endmodule

// File: tb/tb_decade_count_sequencer.sv
// Randomized bench: two sequencers (TICK_DIV 1 and 4) against an integer-valued reference model.
module tb_decade_count_sequencer;

  logic       Clk;
  logic       Clr;
  logic       start, stop, clear, load, auto_reload;
  logic [7:0] preset, target;

  logic [7:0] q0, q1;
  logic       busy0, busy1, tc0, tc1;
  logic [1:0] st0, st1;

  int n_checks;
  int n_errors;

  // Model state per instance: count as a plain integer 0..99.
  int m_q  [2];
  int m_st [2];
  int m_pre[2];
  int m_tc [2];
  int div  [2];

  localparam int Idle = 0, Run = 1, Pause = 2, Done = 3;

  decade_count_sequencer #(.NDIG(2), .TICK_DIV(1)) u_dut0 (
    .Clk(Clk), .Clr(Clr), .start(start), .stop(stop), .clear(clear), .load(load),
    .auto_reload(auto_reload), .preset(preset), .target(target),
    .Q(q0), .busy(busy0), .tc_pulse(tc0), .state(st0)
  );

  decade_count_sequencer #(.NDIG(2), .TICK_DIV(4)) u_dut1 (
    .Clk(Clk), .Clr(Clr), .start(start), .stop(stop), .clear(clear), .load(load),
    .auto_reload(auto_reload), .preset(preset), .target(target),
    .Q(q1), .busy(busy1), .tc_pulse(tc1), .state(st1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] lo, hi;
    lo = 4'(v % 10);
    hi = 4'((v / 10) % 10);
    return {hi, lo};
  endfunction

  function automatic int digit_val(input logic [3:0] d);
    return (d > 4'd9) ? 0 : int'(d);
  endfunction

  // Decimal value of target, or -1 if it can never match.
  function automatic int target_val(input logic [7:0] t);
    if (t[3:0] > 4'd9 || t[7:4] > 4'd9) return -1;
    return int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_st[k] = Idle; m_pre[k] = 0; m_tc[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0;
      if (clear) begin
        m_q[k] = 0; m_pre[k] = 0; m_st[k] = Idle;
      end else if (load) begin
        m_q[k] = digit_val(preset[7:4]) * 10 + digit_val(preset[3:0]);
        m_pre[k] = 0; m_st[k] = Idle;
      end else if (stop) begin
        if (m_st[k] == Run) m_st[k] = Pause;
      end else if (m_st[k] == Run) begin
        if (m_pre[k] == div[k] - 1) begin
          m_pre[k] = 0;
          if (m_q[k] == target_val(target)) begin
            m_tc[k] = 1;
            if (auto_reload) m_q[k] = 0;
            else             m_st[k] = Done;
          end else begin
            m_q[k] = (m_q[k] + 1) % 100;
          end
        end else begin
          m_pre[k]++;
        end
      end else if (start) begin
        if (m_st[k] == Done) begin
          m_q[k] = 0; m_pre[k] = 0;
        end
        m_st[k] = Run;
      end
    end
  endtask

  task automatic check_all();
    check_eq("q0",     32'(q0),    32'(to_bcd(m_q[0])));
    check_eq("state0", 32'(st0),   32'(m_st[0]));
    check_eq("busy0",  32'(busy0), 32'(m_st[0] == Run));
    check_eq("tc0",    32'(tc0),   32'(m_tc[0]));
    check_eq("q1",     32'(q1),    32'(to_bcd(m_q[1])));
    check_eq("state1", 32'(st1),   32'(m_st[1]));
    check_eq("busy1",  32'(busy1), 32'(m_st[1] == Run));
    check_eq("tc1",    32'(tc1),   32'(m_tc[1]));
  endtask

  task automatic new_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) target = 8'($urandom);
    else if (r < 3) target = 8'h99;
    else target = to_bcd($urandom_range(0, 25));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    div[0] = 1;
    div[1] = 4;
    start = 0; stop = 0; clear = 0; load = 0; auto_reload = 0;
    preset = 8'h00;
    target = 8'h05;
    Clr = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge Clk);
    Clr = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clk);
      check_all();

      // Periodic async reset mid-count: outputs must clear without a clock edge.
      if (cyc % 700 == 350) begin
        Clr = 1'b0;
        #1;
        model_reset();
        check_eq("rst_q0",  32'(q0),  32'h0);
        check_eq("rst_st1", 32'(st1), 32'h0);
        check_eq("rst_tc1", 32'(tc1), 32'h0);
        check_all();
        #1;
        Clr = 1'b1;
      end

      clear = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 99) < 4);
      start = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
      if (load) begin
        preset = 8'($urandom);
        new_target();
      end

      @(posedge Clk);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
